// File: rtl/moore_tx_pkg.sv
// Shared types and constants for the Moore serial transmitter.
// State encoding, line levels and counter width helper.
package moore_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } tx_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Per-bit cycle timer with synchronous clear.
// tc flags the last cycle of the current bit period.
module tx_bit_timer
  import moore_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc
);

  localparam int TW = cnt_width(BIT_CYCLES);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign tc = (cnt_q == TW'(BIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/moore_serial_tx.sv
// Moore serial frame transmitter: start bit, LSB-first data, stop bit.
// Outputs are registered copies of next-state decode.
module moore_serial_tx
  import moore_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             inputClk,
  input  logic             inputR,
  input  logic [WIDTH-1:0] inputData,
  input  logic             inputValid,
  output logic             outputReady,
  output logic             outputBit,
  output logic             outputFrame,
  output logic             outputDone
);

  localparam int IW = cnt_width(WIDTH);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             bit_q, bit_d;
  logic             ready_q, ready_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             tc;

  tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk(inputClk),
    .rst(inputR),
    .clr(state_q == ST_IDLE),
    .tc (tc)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (inputValid) begin
          state_d = ST_START;
          shift_d = inputData;
          idx_d   = '0;
        end
      end
      ST_START: begin
        if (tc) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tc) begin
          shift_d = shift_q >> 1;
          if (idx_q == IW'(WIDTH - 1)) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode from next state so outputs line up with the state register.
  always_comb begin
    bit_d   = LINE_IDLE;
    ready_d = 1'b0;
    frame_d = 1'b0;
    unique case (1'b1)
      (state_d == ST_IDLE): begin
        bit_d   = LINE_IDLE;
        ready_d = 1'b1;
      end
      (state_d == ST_START): bit_d = START_LEVEL;
      (state_d == ST_DATA): begin
        bit_d   = shift_d[0];
        frame_d = 1'b1;
      end
      (state_d == ST_STOP): bit_d = STOP_LEVEL;
      default: bit_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge inputClk) begin
    if (inputR) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      bit_q   <= LINE_IDLE;
      ready_q <= 1'b1;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign outputReady = ready_q;
  assign outputBit   = bit_q;
  assign outputFrame = frame_q;
  assign outputDone  = done_q;

endmodule

// File: tb/tb_moore_serial_tx.sv
// Bench for moore_serial_tx: frame-position model plus literal pins.
// Second instance covers WIDTH=1, BIT_CYCLES=1.
module tb_moore_serial_tx;

  localparam int W  = 8;
  localparam int B  = 4;
  localparam int FL = (W + 2) * B;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       rdy, bitq, frm, dn;
  logic [0:0] data2;
  logic       valid2;
  logic       rdy2, bit2, frm2, dn2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moore_serial_tx #(.WIDTH(W), .BIT_CYCLES(B)) dut (
    .inputClk   (clk),
    .inputR     (rst),
    .inputData  (data),
    .inputValid (valid),
    .outputReady(rdy),
    .outputBit  (bitq),
    .outputFrame(frm),
    .outputDone (dn)
  );

  moore_serial_tx #(.WIDTH(1), .BIT_CYCLES(1)) dut2 (
    .inputClk   (clk),
    .inputR     (rst),
    .inputData  (data2),
    .inputValid (valid2),
    .outputReady(rdy2),
    .outputBit  (bit2),
    .outputFrame(frm2),
    .outputDone (dn2)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the frame, -1 when idle.
  int         pos;
  logic [7:0] word;
  logic       mdone;
  bit         mv = 1'b0;
  int         slot;
  logic       eb;

  always @(posedge clk) begin
    if (rst) begin
      pos   = -1;
      mdone = 1'b0;
      mv    = 1'b1;
    end else if (mv) begin
      mdone = 1'b0;
      if (pos < 0) begin
        if (valid) begin
          pos  = 0;
          word = data;
        end
      end else begin
        pos++;
        if (pos == FL) begin
          pos   = -1;
          mdone = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      slot = (pos < 0) ? 0 : pos / B;
      if (pos < 0)        eb = 1'b1;
      else if (slot == 0) eb = 1'b0;
      else if (slot <= W) eb = word[slot-1];
      else                eb = 1'b1;
      chk("model_bit", bitq, eb);
      chk("model_ready", rdy, pos < 0);
      chk("model_frame", frm, pos >= 0 && slot >= 1 && slot <= W);
      chk("model_done", dn, mdone);
    end
  end

  task automatic wait_done(input string nm, input int lim);
    int to = 0;
    while (dn !== 1'b1 && to < lim) begin
      @(negedge clk);
      to++;
    end
    chk(nm, dn, 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    valid2 = 1'b0;
    data2  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bit", bitq, 1'b1);
    chk("rst_ready", rdy, 1'b1);
    chk("rst_frame", frm, 1'b0);
    chk("rst_done", dn, 1'b0);
    chk("rst2_bit", bit2, 1'b1);
    chk("rst2_ready", rdy2, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Single frame 0xA5
    valid = 1'b1;
    data  = 8'hA5;
    for (int n = 0; n <= 41; n++) begin
      @(negedge clk);
      if (n == 0) begin
        valid = 1'b0;
        chk("a5_start", bitq, 1'b0);
        chk("a5_start_rdy", rdy, 1'b0);
      end
      if (n == 4)  chk("a5_d0", bitq, 1'b1);
      if (n == 8)  chk("a5_d1", bitq, 1'b0);
      if (n == 20) chk("a5_d4", bitq, 1'b0);
      if (n == 24) chk("a5_d5", bitq, 1'b1);
      if (n == 32) begin
        chk("a5_d7", bitq, 1'b1);
        chk("a5_d7_frame", frm, 1'b1);
      end
      if (n == 36) begin
        chk("a5_stop", bitq, 1'b1);
        chk("a5_stop_frame", frm, 1'b0);
      end
      if (n == 39) chk("a5_done_early", dn, 1'b0);
      if (n == 40) begin
        chk("a5_done", dn, 1'b1);
        chk("a5_done_rdy", rdy, 1'b1);
      end
      if (n == 41) chk("a5_done_once", dn, 1'b0);
    end

    // Held valid: 0x3C then 0xFF, then data changed mid-frame
    valid = 1'b1;
    data  = 8'h3C;
    @(negedge clk);
    chk("hv_first_accept", rdy, 1'b0);
    data = 8'hFF;
    wait_done("hv_done_seen", 100);
    chk("hv_gap_ready", rdy, 1'b1);
    @(negedge clk);
    chk("hv_second_accept", rdy, 1'b0);
    chk("hv_second_start", bitq, 1'b0);
    valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 12) data = 8'h00;
      if (n == 20) begin
        chk("ign_bit", bitq, 1'b1);
        chk("ign_frame", frm, 1'b1);
      end
    end
    wait_done("ff_done", 60);
    @(negedge clk);

    // Reset during data bit 3 of 0x5A
    valid = 1'b1;
    data  = 8'h5A;
    for (int n = 0; n <= 17; n++) begin
      @(negedge clk);
      if (n == 0) valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rmf_bit", bitq, 1'b1);
    chk("rmf_ready", rdy, 1'b1);
    chk("rmf_frame", frm, 1'b0);
    chk("rmf_done", dn, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rmf_no_done", dn, 1'b0);
    valid = 1'b1;
    data  = 8'h96;
    @(negedge clk);
    valid = 1'b0;
    chk("fresh_start", bitq, 1'b0);
    wait_done("fresh_done", 60);
    @(negedge clk);

    // WIDTH=1, BIT_CYCLES=1
    valid2 = 1'b1;
    data2  = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      if (n == 0) begin
        valid2 = 1'b0;
        chk("e_start_bit", bit2, 1'b0);
        chk("e_start_rdy", rdy2, 1'b0);
      end
      if (n == 1) begin
        chk("e_data_bit", bit2, 1'b1);
        chk("e_data_frame", frm2, 1'b1);
      end
      if (n == 2) begin
        chk("e_stop_bit", bit2, 1'b1);
        chk("e_stop_frame", frm2, 1'b0);
        chk("e_stop_done", dn2, 1'b0);
      end
      if (n == 3) begin
        chk("e_idle_bit", bit2, 1'b1);
        chk("e_idle_rdy", rdy2, 1'b1);
        chk("e_idle_done", dn2, 1'b1);
      end
      if (n == 4) chk("e_done_once", dn2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
